// File: rtl/coin_acc_pkg.sv
// Shared types and constants for the coin acceptor front end.
package coin_acc_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        DEBOUNCE     = 2'b01,
        WAIT_RELEASE = 2'b10,
        HOLDOFF      = 2'b11
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/coin_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module coin_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Debounces the two coin-slot sensors into single-cycle coin codes.
// Optional stuck-sensor detection is enabled by COIN_ACCEPTOR_STUCK_DETECT_EN.
//
// state        | meaning
// IDLE         | waiting for any sensor activity
// DEBOUNCE     | candidate sample pair must stay stable
// WAIT_RELEASE | coin emitted, waiting for a stable all-clear
// HOLDOFF      | forced gap before the next coin may start
module coin_acceptor
    import coin_acc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 2,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sense5,
    input  logic       sense10,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy,
    output logic       fault
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
        HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255 ||
        STUCK_CYCLES < 1 || STUCK_CYCLES > 255) begin : g_param_err
        $error("coin_acceptor: parameter out of range");
    end

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLDOFF_CYCLES);

    logic             s5, s10;
    logic [1:0]       samp;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       cand, cand_nxt;
    logic [1:0]       coin_nxt;
    logic             reject_nxt;
    logic             stuck;

    coin_sync2 u_sync5  (.clk(clk), .rst_n(rst_n), .d(sense5),  .q(s5));
    coin_sync2 u_sync10 (.clk(clk), .rst_n(rst_n), .d(sense10), .q(s10));

    assign samp = {s10, s5};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            cand   <= COIN_NONE;
            coin   <= COIN_NONE;
            reject <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            cand   <= cand_nxt;
            coin   <= coin_nxt;
            reject <= reject_nxt;
            busy   <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cand_nxt   = cand;
        coin_nxt   = COIN_NONE;
        reject_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (samp != 2'b00) begin
                    cand_nxt  = samp;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (samp != cand) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == DEB_MAX) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_RELEASE;
                    if (cand == COIN_5 || cand == COIN_10)
                        coin_nxt = cand;
                    else
                        reject_nxt = 1'b1;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            WAIT_RELEASE: begin
                // A latched fault parks the FSM here so nothing more is emitted.
                if (samp != 2'b00) begin
                    cnt_nxt = '0;
                end else if (sat_inc(cnt) == DEB_MAX && !stuck) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = HOLDOFF;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            HOLDOFF: begin
                if (cnt >= HOLD_MAX) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef COIN_ACCEPTOR_STUCK_DETECT_EN
    localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_CYCLES);

    logic [CNT_W-1:0] stuck_tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_tmr <= '0;
            fault     <= 1'b0;
        end else begin
            if (state == WAIT_RELEASE)
                stuck_tmr <= sat_inc(stuck_tmr);
            else
                stuck_tmr <= '0;
            if (state == WAIT_RELEASE && stuck_tmr == STUCK_MAX)
                fault <= 1'b1;
        end
    end

    assign stuck = fault;
`else
    assign fault = 1'b0;
    assign stuck = 1'b0;
`endif

endmodule
